seqdet_scan_ctrl: RTL and testbench

// Scan controller for the serial pattern detector path. Accepts parallel words over a

---
 rtl/seqdet_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_seqdet_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seqdet_scan_ctrl.sv
// seqdet_scan_ctrl
// Scan controller for the serial pattern detector. A parallel word is accepted
// over a valid/ready handshake. It is then shifted MSB-first into a PAT_W-bit
// history register, one bit per clock. Every occurrence of PATTERN is flagged,
// including overlapping ones, and the matches are counted with saturation.
// A one-cycle done pulse marks the end of the scan.
module seqdet_scan_ctrl #(
  parameter int               DATA_W    = 8,
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
  parameter int               CNT_W     = 4,
  parameter int               KEEP_HIST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic              ser_vld,
  output logic              ser_bit,
  output logic              match,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PRE  = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   word_q;
  logic [PAT_W-1:0]    hist_q;
  logic [FILL_W-1:0]   fill_q;
  logic [IDX_W-1:0]    bit_idx_q;
  logic [CNT_W-1:0]    match_cnt_q;
  logic                match_q;
  logic                done_q;

  logic                cur_bit_s;
  logic [PAT_W-1:0]    hist_d;
  logic [FILL_W-1:0]   fill_d;
  logic                hit_s;
  logic [CNT_W-1:0]    match_cnt_d;
  logic                last_shift_s;
  logic                accept_s;

  // Next-value datapath for one shift step: the new history window, fill level, hit and count.
  always_comb begin
    cur_bit_s    = word_q[LAST_IDX - bit_idx_q];
    hist_d       = PAT_W'({hist_q, cur_bit_s});
    last_shift_s = (bit_idx_q == LAST_IDX);
    accept_s     = (state_q == ST_IDLE) && in_valid && !abort;
    if (fill_q == FILL_FULL) begin
      fill_d = FILL_FULL;
    end else begin
      fill_d = fill_q + FILL_W'(1);
    end
    // A hit only counts once PAT_W real bits have entered since the last clear.
    hit_s = (hist_d == PATTERN) && (fill_q >= FILL_PRE);
    if (hit_s && (match_cnt_q != CNT_MAX)) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end else begin
      match_cnt_d = match_cnt_q;
    end
  end

  // Controller FSM: accept, shift DATA_W bits, one done cycle; abort drops straight to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      bit_idx_q   <= '0;
      match_cnt_q <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      match_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_SHIFT;
            word_q      <= in_data;
            bit_idx_q   <= '0;
            match_cnt_q <= '0;
            if (KEEP_HIST == 0) begin
              hist_q <= '0;
              fill_q <= '0;
            end else begin
              hist_q <= hist_q;
              fill_q <= fill_q;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            // Partial count and history are deliberately kept for observation.
            state_q <= ST_IDLE;
          end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= hit_s;
            match_cnt_q <= match_cnt_d;
            if (last_shift_s) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              bit_idx_q <= '0;
            end else begin
              state_q   <= ST_SHIFT;
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and observe outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    ser_vld   = (state_q == ST_SHIFT);
    ser_bit   = (state_q == ST_SHIFT) && cur_bit_s;
    match     = match_q;
    done      = done_q;
    match_cnt = match_cnt_q;
  end

endmodule

// File: tb/tb_seqdet_scan_ctrl.sv
// Bench for seqdet_scan_ctrl. Three instances share one stimulus stream:
// u0 uses the defaults, u1 keeps history across words, and u2 has a 1-bit counter.
// A behavioural model keeps the raw bit stream and scans its tail for the pattern.
module tb_seqdet_scan_ctrl;

  localparam int NI = 3;
  localparam int PW = 4;
  localparam int KEEP [NI] = '{0, 1, 0};
  localparam int CMAX [NI] = '{15, 15, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       abort;
  logic [7:0] in_data;

  logic       rdy [NI];
  logic       sv  [NI];
  logic       sb  [NI];
  logic       mt  [NI];
  logic       bs  [NI];
  logic       dn  [NI];
  logic [3:0] cnt [NI];
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic [0:0] cnt2;

  assign cnt[0] = cnt0;
  assign cnt[1] = cnt1;
  assign cnt[2] = {3'b000, cnt2};

  always #5 clk = ~clk;

  seqdet_scan_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .abort(abort), .ser_vld(sv[0]), .ser_bit(sb[0]), .match(mt[0]), .busy(bs[0]),
    .done(dn[0]), .match_cnt(cnt0));

  seqdet_scan_ctrl #(.KEEP_HIST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .abort(abort), .ser_vld(sv[1]), .ser_bit(sb[1]), .match(mt[1]), .busy(bs[1]),
    .done(dn[1]), .match_cnt(cnt1));

  seqdet_scan_ctrl #(.CNT_W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
    .abort(abort), .ser_vld(sv[2]), .ser_bit(sb[2]), .match(mt[2]), .busy(bs[2]),
    .done(dn[2]), .match_cnt(cnt2));

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model state: phase 0 idle / 1 scanning / 2 done, plus the full bit stream since last clear.
  int         ph   [NI];
  int         pos  [NI];
  int         mcnt [NI];
  int         sn   [NI];
  bit         mexp [NI];
  logic [7:0] wd   [NI];
  bit         sbuf [NI][8192];
  logic [3:0] pat_v = 4'b1011;

  int mask [NI];
  int cntd [NI];
  int lowc;
  int dcount;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit tail_hit(input int i);
    if (sn[i] < PW) return 1'b0;
    for (int k = 0; k < PW; k++) begin
      if (sbuf[i][sn[i] - PW + k] != pat_v[PW - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model, advanced on every active edge or on reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < NI; i++) begin
        if (rst_n !== 1'b1) begin
          ph[i] = 0; pos[i] = 0; mcnt[i] = 0; sn[i] = 0; mexp[i] = 1'b0; wd[i] = 8'h00;
        end else begin
          mexp[i] = 1'b0;
          if (ph[i] == 0) begin
            if (in_valid && !abort) begin
              wd[i] = in_data; pos[i] = 0; mcnt[i] = 0; ph[i] = 1;
              if (KEEP[i] == 0) sn[i] = 0;
            end
          end else if (ph[i] == 1) begin
            if (abort) begin
              ph[i] = 0;
            end else begin
              sbuf[i][sn[i]] = wd[i][7 - pos[i]];
              sn[i]++;
              mexp[i] = tail_hit(i);
              if (mexp[i] && mcnt[i] < CMAX[i]) mcnt[i]++;
              pos[i]++;
              if (pos[i] == 8) ph[i] = 2;
            end
          end else begin
            ph[i] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on && rst_n === 1'b1) begin
        for (int i = 0; i < NI; i++) begin
          chk($sformatf("u%0d.in_ready", i), rdy[i], (ph[i] == 0) ? 1 : 0);
          chk($sformatf("u%0d.busy", i), bs[i], (ph[i] != 0) ? 1 : 0);
          chk($sformatf("u%0d.done", i), dn[i], (ph[i] == 2) ? 1 : 0);
          chk($sformatf("u%0d.ser_vld", i), sv[i], (ph[i] == 1) ? 1 : 0);
          chk($sformatf("u%0d.match", i), mt[i], int'(mexp[i]));
          chk($sformatf("u%0d.match_cnt", i), cnt[i], mcnt[i]);
          if (ph[i] == 1) chk($sformatf("u%0d.ser_bit", i), sb[i], int'(wd[i][7 - pos[i]]));
        end
      end
    end
  end

  // Present a word and return just after its accept edge; data is then scrambled or replaced.
  task automatic accept(input logic [7:0] d, input bit hold, input logic [7:0] nxt);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (rdy[0] !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", rdy[0], 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    in_data = hold ? nxt : 8'($urandom);
  endtask

  // Starting after an accept edge, record match pulses per edge index and count at done.
  task automatic wait_done();
    bit fin;
    fin  = 1'b0;
    lowc = 0;
    for (int i = 0; i < NI; i++) begin
      mask[i] = 0;
      cntd[i] = -1;
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (mt[i] === 1'b1) mask[i] |= (1 << k);
        if (dn[i] === 1'b1) cntd[i] = int'(cnt[i]);
      end
      if (rdy[0] === 1'b1) begin
        fin = 1'b1;
        break;
      end
      lowc++;
    end
    chk("scan_finished_in_time", 32'(fin), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset u%0d.in_ready", i), rdy[i], 1);
      chk($sformatf("reset u%0d.busy", i), bs[i], 0);
      chk($sformatf("reset u%0d.done", i), dn[i], 0);
      chk($sformatf("reset u%0d.match", i), mt[i], 0);
      chk($sformatf("reset u%0d.match_cnt", i), cnt[i], 0);
    end
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Single match at E4, done after E8, ready low for 9 cycles.
    accept(8'hB0, 1'b0, 8'h00); wait_done();
    chk("t1 mask", mask[0], 16);
    chk("t1 cnt", cntd[0], 1);
    chk("t1 cnt sat1", cntd[2], 1);
    chk("t1 busy cycles", lowc, 9);

    // Two matches at E5 and E8.
    accept(8'h5B, 1'b0, 8'h00); wait_done();
    chk("t2 mask", mask[0], 288);
    chk("t2 cnt", cntd[0], 2);
    chk("t2 cnt keep", cntd[1], 2);
    chk("t2 cnt sat1", cntd[2], 1);

    // Back-to-back FF then 00 with valid held; second accept lands on E10.
    accept(8'hFF, 1'b1, 8'h00); wait_done();
    chk("t3a busy cycles", lowc, 9);
    chk("t3a cnt", cntd[0], 0);
    @(posedge clk); #1; in_valid = 1'b0; in_data = 8'($urandom);
    wait_done();
    chk("t3b busy cycles", lowc, 9);
    chk("t3b cnt", cntd[0], 0);

    // 01 then 60: only the history-keeping instance sees 1011 across the boundary.
    accept(8'h01, 1'b0, 8'h00); wait_done();
    accept(8'h60, 1'b0, 8'h00); wait_done();
    chk("t4 cnt cleared", cntd[0], 0);
    chk("t4 mask cleared", mask[0], 0);
    chk("t4 mask keep", mask[1], 8);
    chk("t4 cnt keep", cntd[1], 1);

    // BB: two pulses, 1-bit counter saturates.
    accept(8'hBB, 1'b0, 8'h00); wait_done();
    chk("t5 mask sat1", mask[2], 272);
    chk("t5 cnt sat1", cntd[2], 1);
    chk("t5 cnt wide", cntd[0], 2);

    // Abort sampled at E3: idle next cycle, no done.
    accept(8'hB0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("t6 ready after abort", rdy[0], 1);
    chk("t6 busy after abort", bs[0], 0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn[0] === 1'b1) dcount++;
    end
    chk("t6 no done after abort", dcount, 0);

    // Reset asserted just after E5 of a scan.
    accept(8'hB0, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    chk("t6 match before reset", mt[0], 1);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midreset u%0d.in_ready", i), rdy[i], 1);
      chk($sformatf("midreset u%0d.busy", i), bs[i], 0);
      chk($sformatf("midreset u%0d.ser_vld", i), sv[i], 0);
      chk($sformatf("midreset u%0d.match_cnt", i), cnt[i], 0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic with occasional aborts and pattern-rich words.
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      abort    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       in_data = 8'hBB;
        1:       in_data = 8'h5B;
        2:       in_data = 8'h2D;
        default: in_data = 8'($urandom);
      endcase
    end
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    repeat (12) @(negedge clk);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
